// File: rtl/collision_scheduler_pkg.sv
// Shared slot-packing constants and sweep state encoding for the collision
// scheduler and the enemy manager.
package collision_scheduler_pkg;

   localparam int COORD_W = 10;
   localparam int EXT_W   = 11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } sweep_state_t;

   function automatic logic [EXT_W-1:0] extend_coord(input logic [COORD_W-1:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test. Box A sits at (ax,ay), box B
// at (bx,by); sums are widened by one bit so edges near the screen limit cannot wrap.
module aabb_overlap
   import collision_scheduler_pkg::*;
#(
   parameter int A_W = 2,
   parameter int A_H = 6,
   parameter int B_W = 16,
   parameter int B_H = 16
) (
   input  logic [COORD_W-1:0] ax,
   input  logic [COORD_W-1:0] ay,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   output logic               overlap
);

   logic [EXT_W-1:0] ax_e, ay_e, bx_e, by_e;

   assign ax_e = extend_coord(ax);
   assign ay_e = extend_coord(ay);
   assign bx_e = extend_coord(bx);
   assign by_e = extend_coord(by);

   assign overlap = (ax_e < bx_e + EXT_W'(B_W)) &&
                    (ax_e + EXT_W'(A_W) > bx_e) &&
                    (ay_e < by_e + EXT_W'(B_H)) &&
                    (ay_e + EXT_W'(A_H) > by_e);

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame bullet-vs-enemy collision sweep: one shared box comparator walks every
// (bullet, enemy) pair of a frame snapshot and commits the hits as one-cycle pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for frame_start; snapshot taken on acceptance
//   ST_SCAN   | one pair (b,e) per cycle, enemy index innermost
//   ST_COMMIT | pending masks/count pushed to the outputs, then cleared
module collision_scheduler
   import collision_scheduler_pkg::*;
#(
   parameter int BULLET_COUNT = 8,
   parameter int ENEMY_COUNT  = 4,
   parameter int BULLET_W     = 2,
   parameter int BULLET_H     = 6,
   parameter int ENEMY_W      = 16,
   parameter int ENEMY_H      = 16
) (
   input  logic                               clk25,
   input  logic                               rst_n,
   input  logic                               frame_start,
   input  logic [COORD_W*BULLET_COUNT-1:0]    bullet_x_flat,
   input  logic [COORD_W*BULLET_COUNT-1:0]    bullet_y_flat,
   input  logic [BULLET_COUNT-1:0]            bullet_active_flat,
   input  logic [COORD_W*ENEMY_COUNT-1:0]     enemy_x_flat,
   input  logic [COORD_W*ENEMY_COUNT-1:0]     enemy_y_flat,
   input  logic [ENEMY_COUNT-1:0]             enemy_active_flat,
   output logic [BULLET_COUNT-1:0]            bullet_hit,
   output logic [ENEMY_COUNT-1:0]             enemy_hit,
   output logic [$clog2(ENEMY_COUNT+1)-1:0]   hit_count,
   output logic                               commit,
   output logic                               busy,
   output logic                               overrun
);

   localparam int BI_W  = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
   localparam int EI_W  = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
   localparam int CNT_W = $clog2(ENEMY_COUNT+1);

   sweep_state_t                      state;
   logic [BI_W-1:0]                   b_idx;
   logic [EI_W-1:0]                   e_idx;
   logic [COORD_W*BULLET_COUNT-1:0]   snap_bx, snap_by;
   logic [BULLET_COUNT-1:0]           snap_ba;
   logic [COORD_W*ENEMY_COUNT-1:0]    snap_ex, snap_ey;
   logic [ENEMY_COUNT-1:0]            snap_ea;
   logic [BULLET_COUNT-1:0]           pend_b;
   logic [ENEMY_COUNT-1:0]            pend_e;
   logic [CNT_W-1:0]                  pend_cnt;

   logic [COORD_W-1:0] cur_bx, cur_by, cur_ex, cur_ey;
   logic               boxes_overlap;
   logic               pair_hit;
   logic               last_b, last_e;

   assign cur_bx = snap_bx[int'(b_idx)*COORD_W +: COORD_W];
   assign cur_by = snap_by[int'(b_idx)*COORD_W +: COORD_W];
   assign cur_ex = snap_ex[int'(e_idx)*COORD_W +: COORD_W];
   assign cur_ey = snap_ey[int'(e_idx)*COORD_W +: COORD_W];

   aabb_overlap #(
      .A_W (BULLET_W),
      .A_H (BULLET_H),
      .B_W (ENEMY_W),
      .B_H (ENEMY_H)
   ) u_overlap (
      .ax      (cur_bx),
      .ay      (cur_by),
      .bx      (cur_ex),
      .by      (cur_ey),
      .overlap (boxes_overlap)
   );

   // Already-matched slots are masked so lower indices win on both sides.
   assign pair_hit = boxes_overlap && snap_ba[b_idx] && snap_ea[e_idx] &&
                     !pend_b[b_idx] && !pend_e[e_idx];
   assign last_b   = (b_idx == BI_W'(BULLET_COUNT-1));
   assign last_e   = (e_idx == EI_W'(ENEMY_COUNT-1));

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         b_idx      <= '0;
         e_idx      <= '0;
         snap_bx    <= '0;
         snap_by    <= '0;
         snap_ba    <= '0;
         snap_ex    <= '0;
         snap_ey    <= '0;
         snap_ea    <= '0;
         pend_b     <= '0;
         pend_e     <= '0;
         pend_cnt   <= '0;
         bullet_hit <= '0;
         enemy_hit  <= '0;
         hit_count  <= '0;
         commit     <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         bullet_hit <= '0;
         enemy_hit  <= '0;
         hit_count  <= '0;
         commit     <= 1'b0;
         if (frame_start && state != ST_IDLE)
            overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  snap_bx <= bullet_x_flat;
                  snap_by <= bullet_y_flat;
                  snap_ba <= bullet_active_flat;
                  snap_ex <= enemy_x_flat;
                  snap_ey <= enemy_y_flat;
                  snap_ea <= enemy_active_flat;
                  b_idx   <= '0;
                  e_idx   <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (pair_hit) begin
                  pend_b[b_idx] <= 1'b1;
                  pend_e[e_idx] <= 1'b1;
                  pend_cnt      <= pend_cnt + CNT_W'(1);
               end
               if (last_e) begin
                  e_idx <= '0;
                  if (last_b) state <= ST_COMMIT;
                  else        b_idx <= b_idx + BI_W'(1);
               end else begin
                  e_idx <= e_idx + EI_W'(1);
               end
            end
            ST_COMMIT: begin
               bullet_hit <= pend_b;
               enemy_hit  <= pend_e;
               hit_count  <= pend_cnt;
               commit     <= 1'b1;
               pend_b     <= '0;
               pend_e     <= '0;
               pend_cnt   <= '0;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: each sweep's expected commit (masks,
// count and the edge it must land on) is queued at frame_start and checked when commit appears.
module tb_collision_scheduler;

   localparam int BC  = 8;
   localparam int EC  = 4;
   localparam int LAT = BC*EC + 1;

   logic          clk25 = 1'b0;
   logic          rst_n;
   logic          frame_start;
   logic [10*BC-1:0] bullet_x_flat, bullet_y_flat;
   logic [BC-1:0]    bullet_active_flat;
   logic [10*EC-1:0] enemy_x_flat, enemy_y_flat;
   logic [EC-1:0]    enemy_active_flat;
   logic [BC-1:0]    bullet_hit;
   logic [EC-1:0]    enemy_hit;
   logic [2:0]       hit_count;
   logic             commit, busy, overrun;

   logic [9:0]    bx [BC];
   logic [9:0]    by [BC];
   logic [BC-1:0] ba;
   logic [9:0]    ex [EC];
   logic [9:0]    ey [EC];
   logic [EC-1:0] ea;

   typedef struct {
      logic [7:0] b;
      logic [3:0] e;
      logic [2:0] c;
      int         edge_at;
   } exp_t;

   exp_t sb[$];
   exp_t x;
   int   compared   = 0;
   int   mismatched = 0;
   int   edge_cnt   = 0;

   always #20 clk25 = ~clk25;
   always @(posedge clk25) edge_cnt++;

   always_comb begin
      bullet_x_flat      = '0;
      bullet_y_flat      = '0;
      enemy_x_flat       = '0;
      enemy_y_flat       = '0;
      bullet_active_flat = ba;
      enemy_active_flat  = ea;
      for (int i = 0; i < BC; i++) begin
         bullet_x_flat[i*10 +: 10] = bx[i];
         bullet_y_flat[i*10 +: 10] = by[i];
      end
      for (int i = 0; i < EC; i++) begin
         enemy_x_flat[i*10 +: 10] = ex[i];
         enemy_y_flat[i*10 +: 10] = ey[i];
      end
   end

   collision_scheduler dut (
      .clk25              (clk25),
      .rst_n              (rst_n),
      .frame_start        (frame_start),
      .bullet_x_flat      (bullet_x_flat),
      .bullet_y_flat      (bullet_y_flat),
      .bullet_active_flat (bullet_active_flat),
      .enemy_x_flat       (enemy_x_flat),
      .enemy_y_flat       (enemy_y_flat),
      .enemy_active_flat  (enemy_active_flat),
      .bullet_hit         (bullet_hit),
      .enemy_hit          (enemy_hit),
      .hit_count          (hit_count),
      .commit             (commit),
      .busy               (busy),
      .overrun            (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every cycle outside a commit must be quiet; a commit pops the oldest expectation.
   always @(negedge clk25) begin
      if (rst_n) begin
         if (commit) begin
            if (sb.size() == 0) begin
               chk("unexpected_commit", 32'(commit), 32'd0);
            end else begin
               x = sb.pop_front();
               chk("commit_edge", 32'(edge_cnt), 32'(x.edge_at));
               chk("bullet_hit", 32'(bullet_hit), 32'(x.b));
               chk("enemy_hit", 32'(enemy_hit), 32'(x.e));
               chk("hit_count", 32'(hit_count), 32'(x.c));
            end
         end else begin
            chk("quiet_bullet_hit", 32'(bullet_hit), 32'd0);
            chk("quiet_enemy_hit", 32'(enemy_hit), 32'd0);
            chk("quiet_hit_count", 32'(hit_count), 32'd0);
         end
         if (sb.size() > 0)
            chk("busy", 32'(busy),
                32'((edge_cnt >= sb[0].edge_at - LAT) && (edge_cnt < sb[0].edge_at)));
      end
   end

   task automatic clear_all();
      for (int i = 0; i < BC; i++) begin bx[i] = 10'd0; by[i] = 10'd0; end
      for (int i = 0; i < EC; i++) begin ex[i] = 10'd0; ey[i] = 10'd0; end
      ba = '0;
      ea = '0;
   endtask

   // Called in the low phase; frame_start is sampled at the next rising edge.
   task automatic start_sweep(input logic [7:0] eb, input logic [3:0] ee,
                              input logic [2:0] ec, input bit expect_commit);
      if (expect_commit) sb.push_back('{eb, ee, ec, edge_cnt + 1 + LAT});
      frame_start = 1'b1;
      @(negedge clk25);
      frame_start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && sb.size() > 0; i++) begin
         @(negedge clk25);
         #1;
      end
      chk("sweep_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic single_hit_geometry();
      clear_all();
      bx[0] = 10'd100; by[0] = 10'd100; ba[0] = 1'b1;
      ex[0] = 10'd95;  ey[0] = 10'd95;  ea[0] = 1'b1;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      frame_start = 1'b0;
      clear_all();
      repeat (3) @(negedge clk25);
      chk("reset_commit", 32'(commit), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      chk("reset_bullet_hit", 32'(bullet_hit), 32'd0);
      rst_n = 1'b1;
      @(negedge clk25);

      // Single hit
      single_hit_geometry();
      start_sweep(8'h01, 4'h1, 3'd1, 1'b1);
      wait_done();

      // Right edge touching: bx == ex+ENEMY_W misses, one pixel inside hits
      bx[0] = 10'd111;
      start_sweep(8'h00, 4'h0, 3'd0, 1'b1);
      wait_done();
      bx[0] = 10'd110;
      start_sweep(8'h01, 4'h1, 3'd1, 1'b1);
      wait_done();

      // Bottom of bullet touching top of enemy: by+BULLET_H == ey misses
      bx[0] = 10'd100; by[0] = 10'd89;
      start_sweep(8'h00, 4'h0, 3'd0, 1'b1);
      wait_done();

      // Near the coordinate limit the enemy's right edge exceeds 10 bits
      clear_all();
      bx[0] = 10'd1020; by[0] = 10'd100; ba[0] = 1'b1;
      ex[0] = 10'd1015; ey[0] = 10'd95;  ea[0] = 1'b1;
      start_sweep(8'h01, 4'h1, 3'd1, 1'b1);
      wait_done();

      // Priority: b0 takes e2, b3 takes e1 (lowest e), b5 surplus on e2
      clear_all();
      ex[0] = 10'd0;   ey[0] = 10'd500; ea[0] = 1'b1;
      ex[1] = 10'd290; ey[1] = 10'd100; ea[1] = 1'b1;
      ex[2] = 10'd300; ey[2] = 10'd100; ea[2] = 1'b1;
      ex[3] = 10'd305; ey[3] = 10'd100; ea[3] = 1'b0;
      bx[0] = 10'd310; by[0] = 10'd105; ba[0] = 1'b1;
      bx[1] = 10'd302; by[1] = 10'd105; ba[1] = 1'b0;
      bx[3] = 10'd302; by[3] = 10'd105; ba[3] = 1'b1;
      bx[5] = 10'd311; by[5] = 10'd105; ba[5] = 1'b1;
      start_sweep(8'h09, 4'h6, 3'd2, 1'b1);
      wait_done();

      // Inactive bullet, inactive enemy
      single_hit_geometry();
      ba[0] = 1'b0;
      start_sweep(8'h00, 4'h0, 3'd0, 1'b1);
      wait_done();
      single_hit_geometry();
      ea[0] = 1'b0;
      start_sweep(8'h00, 4'h0, 3'd0, 1'b1);
      wait_done();

      // Snapshot: activation after the accepting edge is ignored, and vice versa
      single_hit_geometry();
      ba[0] = 1'b0;
      start_sweep(8'h00, 4'h0, 3'd0, 1'b1);
      ba[0] = 1'b1;
      wait_done();
      single_hit_geometry();
      start_sweep(8'h01, 4'h1, 3'd1, 1'b1);
      ba[0] = 1'b0;
      bx[0] = 10'd500;
      wait_done();
      chk("no_overrun_back_to_back", 32'(overrun), 32'd0);

      // Overrun: second frame_start mid-sweep is dropped
      single_hit_geometry();
      start_sweep(8'h01, 4'h1, 3'd1, 1'b1);
      repeat (9) @(negedge clk25);
      start_sweep(8'h00, 4'h0, 3'd0, 1'b0);
      chk("overrun_set", 32'(overrun), 32'd1);
      wait_done();
      repeat (40) @(negedge clk25);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      chk("no_second_sweep_busy", 32'(busy), 32'd0);

      // Reset in mid-scan with a pending hit
      single_hit_geometry();
      start_sweep(8'h00, 4'h0, 3'd0, 1'b0);
      repeat (19) @(negedge clk25);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_commit", 32'(commit), 32'd0);
      chk("rst_bullet_hit", 32'(bullet_hit), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      @(negedge clk25);
      rst_n = 1'b1;
      repeat (40) @(negedge clk25);
      chk("post_reset_busy", 32'(busy), 32'd0);

      // Pending state must not survive the reset
      clear_all();
      start_sweep(8'h00, 4'h0, 3'd0, 1'b1);
      wait_done();
      single_hit_geometry();
      start_sweep(8'h01, 4'h1, 3'd1, 1'b1);
      wait_done();
      repeat (3) @(negedge clk25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Per-frame bullet-vs-enemy collision sequencer.
- Time-shares one axis-aligned-box comparator across all bullet/enemy pairs.
- Produces one-cycle bullet_hit pulses for the bullet controller, plus enemy_hit pulses and a hit count for the enemy/score logic.
- Runs once per frame_start, between the bullet controller and the enemy manager.

Parameters:
- BULLET_COUNT, 8, number of bullet slots (matches bullet controller).
- ENEMY_COUNT, 4, number of enemy slots.
- BULLET_W, 2, bullet box width in pixels.
- BULLET_H, 6, bullet box height in pixels.
- ENEMY_W, 16, enemy box width in pixels.
- ENEMY_H, 16, enemy box height in pixels.

Ports:
- clk25  in  1  25 MHz pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse per frame that starts a sweep.
- bullet_x_flat  in  10*BULLET_COUNT  bullet x, slot i at [i*10 +: 10].
- bullet_y_flat  in  10*BULLET_COUNT  bullet y, same packing.
- bullet_active_flat  in  BULLET_COUNT  bullet slot valid.
- enemy_x_flat  in  10*ENEMY_COUNT  enemy x.
- enemy_y_flat  in  10*ENEMY_COUNT  enemy y.
- enemy_active_flat  in  ENEMY_COUNT  enemy slot valid.
- bullet_hit  out  BULLET_COUNT  one-cycle hit pulse per bullet.
- enemy_hit  out  ENEMY_COUNT  one-cycle hit pulse per enemy.
- hit_count  out  $clog2(ENEMY_COUNT+1)  number of enemies killed this sweep; valid while commit asserted.
- commit  out  1  one-cycle strobe, coincident with the hit pulses.
- busy  out  1  high in SCAN and COMMIT.
- overrun  out  1  sticky; set when frame_start arrives while busy.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, internal masks, indices and snapshot cleared. A reset in mid-sweep discards that sweep; no pulses are emitted.
- IDLE: on a clk25 edge with frame_start=1, latch every input position and active bit into a snapshot, set b=0, e=0 and go to SCAN. Inputs that change after this edge do not affect the sweep.
- SCAN: evaluate one pair (b,e) per cycle, enemy index innermost.
  - Pair is a hit if all of these hold: bullet active, enemy active, bullet b not yet matched, enemy e not yet matched, and the boxes overlap.
  - Overlap: bx < ex+ENEMY_W, bx+BULLET_W > ex, by < ey+ENEMY_H, by+BULLET_H > ey.
  - Compute all sums in 11 bits so they cannot wrap.
  - On a hit, set bit b in the pending bullet mask and bit e in the pending enemy mask, and increment the pending count.
  - Priority: each bullet kills at most one enemy (lowest e wins). Each enemy is killed by at most one bullet (lowest b wins). Surplus overlapping bullets are not consumed.
  - Skipped pairs still take one cycle, so latency is fixed.
  - After pair (BULLET_COUNT-1, ENEMY_COUNT-1), go to COMMIT.
- COMMIT: for exactly one cycle, drive bullet_hit, enemy_hit and hit_count from the pending values and assert commit. Then clear the pending state and return to IDLE. Outside COMMIT, hit outputs and commit are 0.
- Latency: frame_start sampled at edge k; commit and pulses are high in the cycle after edge k+BULLET_COUNT*ENEMY_COUNT+1. With defaults that is 33 edges after frame_start. busy is high for BULLET_COUNT*ENEMY_COUNT+1 cycles.
- frame_start while busy: ignored, the sweep continues unaffected, and overrun is set. overrun clears only on reset.
- frame_start in the COMMIT cycle also counts as busy.
- Back-to-back: frame_start in the first IDLE cycle after COMMIT is accepted.

Decomposition:
- Shared package holds slot-packing constants (coordinate width 10, extended width 11) and the state encoding IDLE/SCAN/COMMIT, reused by the enemy manager.
- One sub-module, aabb_overlap: purely combinational box-overlap test, parameterised by box widths and heights, instantiated once.

Test Plan:
- Single hit:
  - Stimulus: bullet0 active at (100,100), enemy0 active at (95,95), frame_start.
  - Required: at edge k+33 commit=1, bullet_hit=8'h01, enemy_hit=4'h1, hit_count=1. All outputs 0 on the neighbouring cycles.
- Edge boundary:
  - Stimulus: bullet0 at x=111 vs enemy0 at x=95 (bx=ex+ENEMY_W); then bullet0 at x=110.
  - Required: first case no hit; second case bullet_hit=8'h01.
- Priority:
  - Stimulus: bullets 0 and 3 both overlap enemy2; bullet 3 also overlaps enemy1.
  - Required: bullet_hit=8'h09, enemy_hit=4'h6, hit_count=2.
- Inactive slots:
  - Stimulus: geometry overlaps but bullet_active=0, or enemy_active=0, or an input change after the frame_start edge.
  - Required: commit pulse with all-zero masks and hit_count=0.
- Overrun:
  - Stimulus: second frame_start 10 cycles into a sweep.
  - Required: overrun=1 and stays 1; the sweep still commits at k+33; no second sweep starts.
- Reset mid-SCAN:
  - Stimulus: rst_n low at cycle 20 of a sweep with a pending hit.
  - Required: outputs 0 immediately; no commit pulse; busy=0; overrun=0.
